// File: rtl/conv_encoder_param.sv
// Rate-1/N convolutional encoder, constraint length K, generators G.
// Valid/ready on both sides, frame delimiting, optional zero-tail flush.
module conv_encoder_param #(
    parameter int K    = 3,
    parameter int N    = 2,
    parameter     G    = 6'b101_111,
    parameter bit TERM = 1'b1
) (
    input  logic         ck,
    input  logic         rset,
    input  logic         bin,
    input  logic         bin_valid,
    input  logic         bin_last,
    output logic         bin_ready,
    output logic [N-1:0] cout,
    output logic         cout_valid,
    output logic         cout_last,
    input  logic         cout_ready,
    output logic         busy
);

    localparam int SRW     = (K > 1) ? K - 1 : 1;
    localparam bit DO_TAIL = TERM && (K > 1);

    generate
        if ($bits(G) != N * K) begin : g_bad_width
            $fatal(1, "conv_encoder_param: width of G must be N*K");
        end
        if (K < 1 || K > 9) begin : g_bad_k
            $fatal(1, "conv_encoder_param: K out of range 1..9");
        end
        if (N < 2 || N > 4) begin : g_bad_n
            $fatal(1, "conv_encoder_param: N out of range 2..4");
        end
    endgenerate

    localparam logic [N*K-1:0] GV = G;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [SRW-1:0]   sr_q, sr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N-1:0]     cout_q, cout_d;
    logic             cv_q, cv_d;
    logic             cl_q, cl_d;
    logic             load_ok;
    logic             rdy;

    // w[0] is the current bit, w[j] the bit j steps back.
    function automatic logic [K-1:0] window(
        input logic [SRW-1:0] sr,
        input logic           u
    );
        logic [SRW:0] full;
        full = {sr, u};
        return full[K-1:0];
    endfunction

    function automatic logic [SRW-1:0] shift_in(
        input logic [SRW-1:0] sr,
        input logic           u
    );
        logic [SRW:0] full;
        full = {sr, u};
        return (K > 1) ? full[SRW-1:0] : '0;
    endfunction

    function automatic logic [N-1:0] encode(input logic [K-1:0] w);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < K; j++) begin
                r[i] = r[i] ^ (w[j] & GV[i*K+j]);
            end
        end
        return r;
    endfunction

    always_comb begin
        load_ok = !cv_q || cout_ready;
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        cv_d    = cv_q;
        cl_d    = cl_q;
        rdy     = 1'b0;
        unique case (state_q)
            RUN: begin
                rdy = load_ok;
                if (bin_valid && load_ok) begin
                    cout_d = encode(window(sr_q, bin));
                    cv_d   = 1'b1;
                    sr_d   = shift_in(sr_q, bin);
                    if (bin_last && DO_TAIL) begin
                        cl_d    = 1'b0;
                        state_d = FLUSH;
                        cnt_d   = 4'(K - 1);
                    end else begin
                        cl_d = bin_last;
                    end
                end else if (load_ok) begin
                    cv_d = 1'b0;
                    cl_d = 1'b0;
                end
            end
            FLUSH: begin
                // Tail: feed zeros until the trellis is back in state 0.
                if (load_ok) begin
                    cout_d = encode(window(sr_q, 1'b0));
                    cv_d   = 1'b1;
                    sr_d   = shift_in(sr_q, 1'b0);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        cl_d    = 1'b1;
                        state_d = RUN;
                    end else begin
                        cl_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            state_q <= RUN;
            sr_q    <= '0;
            cnt_q   <= '0;
            cout_q  <= '0;
            cv_q    <= 1'b0;
            cl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            cv_q    <= cv_d;
            cl_q    <= cl_d;
        end
    end

    assign bin_ready  = rdy && !rset;
    assign cout       = cout_q;
    assign cout_valid = cv_q;
    assign cout_last  = cl_q;
    assign busy       = (state_q == FLUSH);

endmodule

// File: tb/tb_conv_encoder_param.sv
// Bench for conv_encoder_param: four parameterisations, directed frames,
// queue-based convolution model plus literal symbol sequences.
module tb_conv_encoder_param;

    logic ck = 1'b0;
    logic rset = 1'b1;
    logic bin = 1'b0;
    logic bin_valid = 1'b0;
    logic bin_last = 1'b0;
    logic cout_ready = 1'b1;
    logic [1:0] sel = 2'd0;

    always #5 ck = ~ck;

    logic [3:0] bv;
    wire  [3:0] br, cv, cl, bz;
    wire  [1:0] coA, coB, coD;
    wire  [2:0] coC;

    always_comb begin
        for (int k = 0; k < 4; k++) bv[k] = bin_valid && (sel == 2'(k));
    end

    conv_encoder_param uA (
        .ck(ck), .rset(rset), .bin(bin), .bin_valid(bv[0]),
        .bin_last(bin_last), .bin_ready(br[0]), .cout(coA),
        .cout_valid(cv[0]), .cout_last(cl[0]),
        .cout_ready(cout_ready), .busy(bz[0])
    );

    conv_encoder_param #(.K(3), .N(2), .G(6'b101_111), .TERM(1'b0)) uB (
        .ck(ck), .rset(rset), .bin(bin), .bin_valid(bv[1]),
        .bin_last(bin_last), .bin_ready(br[1]), .cout(coB),
        .cout_valid(cv[1]), .cout_last(cl[1]),
        .cout_ready(cout_ready), .busy(bz[1])
    );

    conv_encoder_param #(.K(1), .N(3), .G(3'b1_1_1), .TERM(1'b1)) uC (
        .ck(ck), .rset(rset), .bin(bin), .bin_valid(bv[2]),
        .bin_last(bin_last), .bin_ready(br[2]), .cout(coC),
        .cout_valid(cv[2]), .cout_last(cl[2]),
        .cout_ready(cout_ready), .busy(bz[2])
    );

    conv_encoder_param #(.K(7), .N(2), .G({7'o133, 7'o171}), .TERM(1'b1)) uD (
        .ck(ck), .rset(rset), .bin(bin), .bin_valid(bv[3]),
        .bin_last(bin_last), .bin_ready(br[3]), .cout(coD),
        .cout_valid(cv[3]), .cout_last(cl[3]),
        .cout_ready(cout_ready), .busy(bz[3])
    );

    logic       cur_br, cur_cv, cur_cl, cur_bz;
    logic [3:0] cur_co;

    always_comb begin
        cur_br = br[sel];
        cur_cv = cv[sel];
        cur_cl = cl[sel];
        cur_bz = bz[sel];
        case (sel)
            2'd0:    cur_co = {2'b00, coA};
            2'd1:    cur_co = {2'b00, coB};
            2'd2:    cur_co = {1'b0, coC};
            default: cur_co = {2'b00, coD};
        endcase
    end

    int n_chk = 0;
    int n_pass = 0;
    int busy_cnt = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: hist[j] is the input bit j steps back; output i is the
    // parity of the generator-i taps over that history.
    int          mK, mN;
    logic [35:0] mG;
    bit          mT;
    bit          hist[$];
    logic [4:0]  exp_q[$];
    logic [4:0]  obs_q[$];

    function automatic logic [3:0] msym();
        logic [3:0] s = '0;
        for (int i = 0; i < mN; i++)
            for (int j = 0; j < mK; j++)
                if (j < hist.size() && mG[i*mK+j] && hist[j]) s[i] = ~s[i];
        return s;
    endfunction

    task automatic mpush(bit u, bit last);
        bit tail = mT && (mK > 1) && last;
        hist.push_front(u);
        exp_q.push_back({last && !tail, msym()});
        if (tail) begin
            for (int t = 1; t < mK; t++) begin
                hist.push_front(1'b0);
                exp_q.push_back({t == mK - 1, msym()});
            end
        end
    endtask

    task automatic setup(logic [1:0] s, int k, int n, logic [35:0] g, bit t);
        sel = s;
        mK = k;
        mN = n;
        mG = g;
        mT = t;
        hist.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send(bit b, bit l);
        bit acc = 1'b0;
        int n = 0;
        bin = b;
        bin_last = l;
        bin_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge ck);
            acc = cur_br;
            @(posedge ck);
            #1;
            n++;
        end
        if (acc) mpush(b, l);
        else begin
            n_chk++;
            $display("FAIL send_timeout: bit not accepted in %0d cycles", n);
        end
        bin_valid = 1'b0;
        bin_last = 1'b0;
    endtask

    task automatic drain(string nm);
        int n = 0;
        while ((exp_q.size() != 0 || cur_cv) && n < 300) begin
            @(posedge ck);
            #1;
            n++;
        end
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_idle"}, int'(cur_cv), 0);
    endtask

    task automatic chk_obs(string nm, logic [39:0] e, int n);
        chk({nm, "_count"}, obs_q.size(), n);
        for (int k = 0; k < n && k < obs_q.size(); k++)
            chk(nm, int'(obs_q[k]), int'(e[(n-1-k)*5 +: 5]));
    endtask

    // Compare process: every transferred symbol against the model.
    always @(negedge ck) begin
        if (!rset) begin
            if (cur_bz) busy_cnt++;
            if (cur_cv && !cout_ready) chk("stall_bin_ready", int'(cur_br), 0);
            if (cur_cv && cout_ready) begin
                obs_q.push_back({cur_cl, cur_co});
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_symbol: got %0h expected none",
                             {cur_cl, cur_co});
                end else begin
                    chk("symbol", int'({cur_cl, cur_co}), int'(exp_q.pop_front()));
                end
            end
        end
    end

    bit tog = 1'b0;
    int ph = 0;
    always @(posedge ck) begin
        if (tog) begin
            #1;
            cout_ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int nl;
        setup(2'd0, 3, 2, 36'b101_111, 1'b1);
        #12;
        chk("rst_cout_valid", int'(cv), 0);
        chk("rst_cout_last", int'(cl), 0);
        chk("rst_busy", int'(bz), 0);
        chk("rst_cout", int'({coA, coB, coC, coD}), 0);
        @(posedge ck);
        #1 rset = 1'b0;
        #1 chk("ready_after_reset", int'(br), 15);

        // Basic frame with tail
        busy_cnt = 0;
        send(1, 0); send(0, 0); send(1, 0); send(1, 1);
        drain("t1");
        chk_obs("t1_seq", {5'b00011, 5'b00001, 5'b00000,
                           5'b00010, 5'b00010, 5'b10011}, 6);
        chk("t1_busy_cycles", busy_cnt, 2);

        // Same frame under backpressure
        obs_q.delete();
        ph = 0;
        tog = 1'b1;
        send(1, 0); send(0, 0); send(1, 0); send(1, 1);
        drain("t2");
        tog = 1'b0;
        @(posedge ck);
        #2 cout_ready = 1'b1;
        chk_obs("t2_seq", {5'b00011, 5'b00001, 5'b00000,
                           5'b00010, 5'b00010, 5'b10011}, 6);

        // Async reset during flush, then a fresh frame
        obs_q.delete();
        send(1, 0); send(0, 0); send(1, 0); send(1, 1);
        chk("t4_in_flush", int'(cur_bz), 1);
        #1 rset = 1'b1;
        #1;
        chk("t4_rst_valid", int'(cur_cv), 0);
        chk("t4_rst_last", int'(cur_cl), 0);
        chk("t4_rst_busy", int'(cur_bz), 0);
        exp_q.delete();
        hist.delete();
        @(posedge ck);
        #1 rset = 1'b0;
        obs_q.delete();
        send(1, 0); send(0, 1);
        drain("t4");
        chk_obs("t4_seq", {5'b00011, 5'b00001, 5'b00011, 5'b10000}, 4);

        // No termination, state carried across frames
        setup(2'd1, 3, 2, 36'b101_111, 1'b0);
        send(1, 0); send(0, 1); send(1, 0); send(1, 1);
        drain("t3");
        chk_obs("t3_seq", {5'b00011, 5'b10001, 5'b00000, 5'b10010}, 4);

        // K=1 repetition code
        setup(2'd2, 1, 3, 36'b111, 1'b1);
        send(1, 0); send(0, 0); send(1, 0); send(1, 1);
        drain("t5");
        chk_obs("t5_seq", {5'b00111, 5'b00000, 5'b00111, 5'b10111}, 4);

        // K=7 random frame, then a single-bit frame from the zero state
        setup(2'd3, 7, 2, 36'({7'o133, 7'o171}), 1'b1);
        for (int i = 0; i < 64; i++) send(1'($urandom % 2), i == 63);
        drain("t6");
        chk("t6_symbols", obs_q.size(), 70);
        nl = 0;
        foreach (obs_q[i]) if (obs_q[i][4]) nl++;
        chk("t6_last_count", nl, 1);
        if (obs_q.size() == 70) chk("t6_last_pos", int'(obs_q[69][4]), 1);
        obs_q.delete();
        send(1, 1);
        drain("t6b");
        chk_obs("t6b_seq", {5'b00011, 5'b00010, 5'b00000, 5'b00011,
                            5'b00011, 5'b00001, 5'b10011}, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/N convolutional encoder with constraint length K and generator polynomials set at elaboration time. It is the successor to the fixed rate-1/2, K=3 encoder. New capabilities:
- valid/ready handshaking on both sides, with backpressure
- frame delimiting
- optional automatic zero-tail termination, which returns the trellis to state 0 at the end of each frame

It sits between the bit source and the channel/puncturing stage of the encoder/decoder test chain.

Parameters:
K, 3, constraint length; shift history is K-1 bits; legal range 1..9
N, 2, output bits per input bit (code rate 1/N); legal range 2..4
G, 6'b101_111, packed generators; G[i*K +: K] is generator i; bit j taps u(t-j), so bit 0 is the current input
TERM, 1, 1 = append K-1 zero tail bits after each frame's last bit; 0 = no termination

Ports:
ck  input  1  clock, rising-edge active
rset  input  1  reset, asynchronous, active-high
bin  input  1  input data bit
bin_valid  input  1  bin/bin_last valid
bin_last  input  1  marks final data bit of a frame
bin_ready  output  1  encoder can accept a bit this cycle
cout  output  N  encoded symbol; cout[i] is the output of generator i
cout_valid  output  1  cout/cout_last valid
cout_last  output  1  final symbol of the frame
cout_ready  input  1  downstream accepts the symbol this cycle
busy  output  1  high while in FLUSH

Behaviour:
- One clock (ck). Reset rset is asynchronous and active-high. All flops clear immediately on rset=1, regardless of ck.
- Reset values:
  - sr (K-1 history bits) = 0
  - state = RUN
  - tail counter = 0
  - cout = 0, cout_valid = 0, cout_last = 0, busy = 0
  - bin_ready = 1 once rset is low
- Encode function: window w = {sr, u} with w[0] = u (current bit) and w[j] = u(t-j). cout[i] = XOR-reduce(w & G[i*K +: K]).
- Output register: single entry.
  - load_ok = !cout_valid || cout_ready.
  - Symbol transfer occurs when cout_valid && cout_ready.
- Latency: a bit accepted at edge n produces a symbol with cout_valid=1 from edge n onward (one registered stage). Throughput is 1 bit/cycle while cout_ready=1.
- State RUN:
  - bin_ready = load_ok.
  - On accept (bin_valid && bin_ready): load cout = f(w), set cout_valid=1, shift sr = {sr[K-3:0], bin}.
  - If bin_last is set on the accepted bit and TERM=1 and K>1: cout_last=0, go to FLUSH with tail counter = K-1.
  - Otherwise cout_last = bin_last.
  - If load_ok and no accept: cout_valid drops to 0.
- State FLUSH:
  - bin_ready = 0, busy = 1.
  - Each cycle with load_ok: encode u=0, load the output register, shift in 0, decrement the tail counter.
  - When the counter goes 1->0: cout_last=1, return to RUN. sr is then all-zero by construction.
- Stall: while cout_valid && !cout_ready, cout, cout_last and sr hold and no input is accepted. bin_valid may stay high without data loss.
- Boundaries:
  - K=1: no history, no tail; cout_last follows bin_last.
  - TERM=0: sr is not cleared between frames; the next frame continues from the current state.
  - A frame of a single bit with bin_last=1 yields 1+(K-1) symbols.
  - A new frame's first bit may be accepted in the cycle immediately after the last tail symbol is loaded. No idle gap is required.
  - rset mid-frame or mid-flush aborts immediately: the pending symbol is discarded and there is no partial cout_last.
- Width rules: cout is exactly N bits. G width must equal N*K; a mismatch is a fatal elaboration error via a generate-time check.

Test Plan:
1. Defaults (K=3, N=2, G=101_111, TERM=1), cout_ready=1. Input 1,0,1,1 with bin_last on the 4th bit -> cout sequence 11,01,00,10,10,11; cout_last only on the 6th symbol; busy high for 2 cycles; sr=0 afterwards.
2. Same stimulus with cout_ready toggling 1,0,0,1,... -> identical symbol sequence; no drops or duplicates; bin_ready low whenever cout_valid && !cout_ready.
3. TERM=0, two back-to-back frames 1,0 / 1,1 -> symbols 11,01,00,10; no tail symbols; cout_last on the 2nd and 4th symbols; state carried across frames.
4. Assert rset asynchronously (mid-cycle) during FLUSH of scenario 1 -> cout_valid, cout_last and busy drop immediately; next frame 1,0 with bin_last -> 11,01,11,00 ... from the zero state.
5. K=1, N=3, G=3'b1_1_1 -> each input bit b gives cout = {b,b,b}; cout_last coincides with bin_last.
6. K=7, N=2, G={7'o133,7'o171}, random 64-bit frame -> symbols match a reference model; exactly 6 tail symbols; final sr=0.
